// File: rtl/axi_core_arbiter.sv
// N-master AXI4 arbiter: independent read and write FSMs share one downstream port.
// Forwarded channels are combinational muxes selected by the registered grant.
module axi_core_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ARB_MODE    = 0,
  parameter int ADDR_SIZE   = 32,
  parameter int ID_WIDTH    = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                   i_aclk,
  input  logic                                   i_areset_n,
  // upstream read address / data
  input  logic [NUM_MASTERS-1:0]                 s_axi_arvalid,
  output logic [NUM_MASTERS-1:0]                 s_axi_arready,
  input  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]   s_axi_arid,
  input  logic [NUM_MASTERS-1:0][ADDR_SIZE-1:0]  s_axi_araddr,
  input  logic [NUM_MASTERS-1:0][7:0]            s_axi_arlen,
  input  logic [NUM_MASTERS-1:0][2:0]            s_axi_arsize,
  input  logic [NUM_MASTERS-1:0][1:0]            s_axi_arburst,
  output logic [NUM_MASTERS-1:0]                 s_axi_rvalid,
  input  logic [NUM_MASTERS-1:0]                 s_axi_rready,
  output logic [ID_WIDTH-1:0]                    s_axi_rid,
  output logic [DATA_WIDTH-1:0]                  s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rlast,
  // upstream write address / data / response
  input  logic [NUM_MASTERS-1:0]                 s_axi_awvalid,
  output logic [NUM_MASTERS-1:0]                 s_axi_awready,
  input  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]   s_axi_awid,
  input  logic [NUM_MASTERS-1:0][ADDR_SIZE-1:0]  s_axi_awaddr,
  input  logic [NUM_MASTERS-1:0][7:0]            s_axi_awlen,
  input  logic [NUM_MASTERS-1:0][2:0]            s_axi_awsize,
  input  logic [NUM_MASTERS-1:0][1:0]            s_axi_awburst,
  input  logic [NUM_MASTERS-1:0]                 s_axi_wvalid,
  output logic [NUM_MASTERS-1:0]                 s_axi_wready,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic [NUM_MASTERS-1:0]                 s_axi_wlast,
  output logic [NUM_MASTERS-1:0]                 s_axi_bvalid,
  input  logic [NUM_MASTERS-1:0]                 s_axi_bready,
  output logic [ID_WIDTH-1:0]                    s_axi_bid,
  output logic [1:0]                             s_axi_bresp,
  // downstream port
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  output logic [ID_WIDTH-1:0]                    m_axi_arid,
  output logic [ADDR_SIZE-1:0]                   m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  output logic [2:0]                             m_axi_arsize,
  output logic [1:0]                             m_axi_arburst,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready,
  input  logic [ID_WIDTH-1:0]                    m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  output logic                                   m_axi_awvalid,
  input  logic                                   m_axi_awready,
  output logic [ID_WIDTH-1:0]                    m_axi_awid,
  output logic [ADDR_SIZE-1:0]                   m_axi_awaddr,
  output logic [7:0]                             m_axi_awlen,
  output logic [2:0]                             m_axi_awsize,
  output logic [1:0]                             m_axi_awburst,
  output logic                                   m_axi_wvalid,
  input  logic                                   m_axi_wready,
  output logic [DATA_WIDTH-1:0]                  m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]                m_axi_wstrb,
  output logic                                   m_axi_wlast,
  input  logic                                   m_axi_bvalid,
  output logic                                   m_axi_bready,
  input  logic [ID_WIDTH-1:0]                    m_axi_bid,
  input  logic [1:0]                             m_axi_bresp,
  // status
  output logic [NUM_MASTERS-1:0]                 o_rd_grant,
  output logic [NUM_MASTERS-1:0]                 o_wr_grant,
  output logic                                   o_rd_busy,
  output logic                                   o_wr_busy
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  rd_state_t rd_state, rd_state_nx;
  wr_state_t wr_state, wr_state_nx;
  logic [IDX_W-1:0] rd_idx, wr_idx, rd_ptr, wr_ptr, rd_win, wr_win;

  // Fixed priority scans from 0; round-robin scans from the pointer with wrap.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (ARB_MODE == 1) ? i : int'(ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_MASTERS - 1) ? '0 : idx + IDX_W'(1);
  endfunction

  assign rd_win = pick(s_axi_arvalid, rd_ptr);
  assign wr_win = pick(s_axi_awvalid, wr_ptr);

  // ---------------- read direction ----------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rd_state   <= RD_IDLE;
      rd_idx     <= '0;
      rd_ptr     <= '0;
      o_rd_grant <= '0;
    end else begin
      rd_state <= rd_state_nx;
      if (rd_state == RD_IDLE && |s_axi_arvalid) begin
        rd_idx     <= rd_win;
        o_rd_grant <= NUM_MASTERS'(1) << rd_win;
      end else if (rd_state == RD_DATA && rd_state_nx == RD_IDLE) begin
        o_rd_grant <= '0;
        rd_ptr     <= next_ptr(rd_idx);
      end
    end
  end

  always_comb begin
    rd_state_nx = rd_state;
    case (rd_state)
      RD_IDLE: if (|s_axi_arvalid) rd_state_nx = RD_ADDR;
      RD_ADDR: if (m_axi_arvalid && m_axi_arready) rd_state_nx = RD_DATA;
      RD_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) rd_state_nx = RD_IDLE;
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    // NOTE: defaults first on every output so no branch leaves a value held (no latch).
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (rd_state)
      RD_ADDR: begin
        m_axi_arvalid         = s_axi_arvalid[rd_idx];
        s_axi_arready[rd_idx] = m_axi_arready;
      end
      RD_DATA: begin
        m_axi_rready         = s_axi_rready[rd_idx];
        s_axi_rvalid[rd_idx] = m_axi_rvalid;
      end
      default: ;
    endcase
  end

  assign o_rd_busy     = (rd_state != RD_IDLE);
  assign m_axi_arid    = s_axi_arid[rd_idx];
  assign m_axi_araddr  = s_axi_araddr[rd_idx];
  assign m_axi_arlen   = s_axi_arlen[rd_idx];
  assign m_axi_arsize  = s_axi_arsize[rd_idx];
  assign m_axi_arburst = s_axi_arburst[rd_idx];
  // R payload is broadcast; only the granted master sees rvalid.
  assign s_axi_rid     = m_axi_rid;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast;

  // ---------------- write direction ----------------
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      wr_state   <= WR_IDLE;
      wr_idx     <= '0;
      wr_ptr     <= '0;
      o_wr_grant <= '0;
    end else begin
      wr_state <= wr_state_nx;
      if (wr_state == WR_IDLE && |s_axi_awvalid) begin
        wr_idx     <= wr_win;
        o_wr_grant <= NUM_MASTERS'(1) << wr_win;
      end else if (wr_state == WR_RESP && wr_state_nx == WR_IDLE) begin
        o_wr_grant <= '0;
        wr_ptr     <= next_ptr(wr_idx);
      end
    end
  end

  always_comb begin
    wr_state_nx = wr_state;
    case (wr_state)
      WR_IDLE: if (|s_axi_awvalid) wr_state_nx = WR_ADDR;
      WR_ADDR: if (m_axi_awvalid && m_axi_awready) wr_state_nx = WR_DATA;
      WR_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) wr_state_nx = WR_RESP;
      WR_RESP: if (m_axi_bvalid && m_axi_bready) wr_state_nx = WR_IDLE;
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    case (wr_state)
      WR_ADDR: begin
        m_axi_awvalid         = s_axi_awvalid[wr_idx];
        s_axi_awready[wr_idx] = m_axi_awready;
      end
      WR_DATA: begin
        m_axi_wvalid         = s_axi_wvalid[wr_idx];
        s_axi_wready[wr_idx] = m_axi_wready;
      end
      WR_RESP: begin
        m_axi_bready         = s_axi_bready[wr_idx];
        s_axi_bvalid[wr_idx] = m_axi_bvalid;
      end
      default: ;
    endcase
  end

  assign o_wr_busy     = (wr_state != WR_IDLE);
  assign m_axi_awid    = s_axi_awid[wr_idx];
  assign m_axi_awaddr  = s_axi_awaddr[wr_idx];
  assign m_axi_awlen   = s_axi_awlen[wr_idx];
  assign m_axi_awsize  = s_axi_awsize[wr_idx];
  assign m_axi_awburst = s_axi_awburst[wr_idx];
  assign m_axi_wdata   = s_axi_wdata[wr_idx];
  assign m_axi_wstrb   = s_axi_wstrb[wr_idx];
  assign m_axi_wlast   = s_axi_wlast[wr_idx];
  assign s_axi_bid     = m_axi_bid;
  assign s_axi_bresp   = m_axi_bresp;

endmodule

// File: tb/tb_axi_core_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter (4 masters each) share
// the same stimulus; expectations are hand-computed per phase.
module tb_axi_core_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus
  logic [N-1:0]        s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready;
  logic [N-1:0][3:0]   s_arid, s_awid, s_wstrb;
  logic [N-1:0][31:0]  s_araddr, s_awaddr, s_wdata;
  logic [N-1:0][7:0]   s_arlen, s_awlen;
  logic [N-1:0][2:0]   s_arsize, s_awsize;
  logic [N-1:0][1:0]   s_arburst, s_awburst;
  logic        m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
  logic [3:0]  m_rid, m_bid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  // round-robin instance outputs
  logic [N-1:0] s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [3:0]   s_rid, s_bid, m_arid, m_awid, m_wstrb;
  logic [31:0]  s_rdata, m_araddr, m_awaddr, m_wdata;
  logic [1:0]   s_rresp, s_bresp, m_arburst, m_awburst;
  logic         s_rlast, m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
  logic [7:0]   m_arlen, m_awlen;
  logic [2:0]   m_arsize, m_awsize;
  logic [N-1:0] rd_grant, wr_grant;
  logic         rd_busy, wr_busy;

  // fixed-priority instance outputs
  logic [N-1:0] fp_s_arready, fp_s_rvalid, fp_s_awready, fp_s_wready, fp_s_bvalid;
  logic [3:0]   fp_s_rid, fp_s_bid, fp_m_arid, fp_m_awid, fp_m_wstrb;
  logic [31:0]  fp_s_rdata, fp_m_araddr, fp_m_awaddr, fp_m_wdata;
  logic [1:0]   fp_s_rresp, fp_s_bresp, fp_m_arburst, fp_m_awburst;
  logic         fp_s_rlast, fp_m_arvalid, fp_m_rready, fp_m_awvalid, fp_m_wvalid, fp_m_wlast, fp_m_bready;
  logic [7:0]   fp_m_arlen, fp_m_awlen;
  logic [2:0]   fp_m_arsize, fp_m_awsize;
  logic [N-1:0] fp_rd_grant, fp_wr_grant;
  logic         fp_rd_busy, fp_wr_busy;

  axi_core_arbiter #(.NUM_MASTERS(N), .ARB_MODE(0)) u_rr (
    .i_aclk(clk), .i_areset_n(rst_n),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready), .s_axi_arid(s_arid),
    .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
    .s_axi_arburst(s_arburst), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awid(s_awid),
    .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
    .s_axi_awburst(s_awburst), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
    .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready), .s_axi_bid(s_bid), .s_axi_bresp(s_bresp),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_arid(m_arid),
    .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
    .m_axi_arburst(m_arburst), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready), .m_axi_awid(m_awid),
    .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
    .o_rd_grant(rd_grant), .o_wr_grant(wr_grant), .o_rd_busy(rd_busy), .o_wr_busy(wr_busy)
  );

  axi_core_arbiter #(.NUM_MASTERS(N), .ARB_MODE(1)) u_fp (
    .i_aclk(clk), .i_areset_n(rst_n),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(fp_s_arready), .s_axi_arid(s_arid),
    .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
    .s_axi_arburst(s_arburst), .s_axi_rvalid(fp_s_rvalid), .s_axi_rready(s_rready),
    .s_axi_rid(fp_s_rid), .s_axi_rdata(fp_s_rdata), .s_axi_rresp(fp_s_rresp), .s_axi_rlast(fp_s_rlast),
    .s_axi_awvalid(s_awvalid), .s_axi_awready(fp_s_awready), .s_axi_awid(s_awid),
    .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
    .s_axi_awburst(s_awburst), .s_axi_wvalid(s_wvalid), .s_axi_wready(fp_s_wready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast),
    .s_axi_bvalid(fp_s_bvalid), .s_axi_bready(s_bready), .s_axi_bid(fp_s_bid), .s_axi_bresp(fp_s_bresp),
    .m_axi_arvalid(fp_m_arvalid), .m_axi_arready(m_arready), .m_axi_arid(fp_m_arid),
    .m_axi_araddr(fp_m_araddr), .m_axi_arlen(fp_m_arlen), .m_axi_arsize(fp_m_arsize),
    .m_axi_arburst(fp_m_arburst), .m_axi_rvalid(m_rvalid), .m_axi_rready(fp_m_rready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_awvalid(fp_m_awvalid), .m_axi_awready(m_awready), .m_axi_awid(fp_m_awid),
    .m_axi_awaddr(fp_m_awaddr), .m_axi_awlen(fp_m_awlen), .m_axi_awsize(fp_m_awsize),
    .m_axi_awburst(fp_m_awburst), .m_axi_wvalid(fp_m_wvalid), .m_axi_wready(m_wready),
    .m_axi_wdata(fp_m_wdata), .m_axi_wstrb(fp_m_wstrb), .m_axi_wlast(fp_m_wlast),
    .m_axi_bvalid(m_bvalid), .m_axi_bready(fp_m_bready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp),
    .o_rd_grant(fp_rd_grant), .o_wr_grant(fp_wr_grant), .o_rd_busy(fp_rd_busy), .o_wr_busy(fp_wr_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One single-beat read with all masters' rready high; grant expectations per instance.
  task automatic rd_single(input string tag, input logic [N-1:0] exp_rr, input logic [N-1:0] exp_fp);
    check({tag, "_idle"}, rd_grant, 0);
    tick;
    check({tag, "_rr"}, rd_grant, exp_rr);
    check({tag, "_fp"}, fp_rd_grant, exp_fp);
    m_arready = 1'b1;
    tick;
    m_arready = 1'b0;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    #1;
    check({tag, "_rvalid"}, s_rvalid, exp_rr);
    tick;
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  beat, cyc;
    logic hs;
    rst_n = 1'b0;
    s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    s_arid = '0; s_awid = '0; s_wstrb = '1; s_araddr = '0; s_awaddr = '0; s_wdata = '0;
    s_arlen = '0; s_awlen = '0; s_arsize = '0; s_awsize = '0; s_arburst = '0; s_awburst = '0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    m_rid = '0; m_bid = '0; m_rdata = '0; m_rresp = '0; m_bresp = '0;
    s_arvalid = 4'b0001;  // request held during reset must not leak out
    #12;
    check("rst_rd_grant", rd_grant, 0);
    check("rst_wr_grant", wr_grant, 0);
    check("rst_rd_busy", rd_busy, 0);
    check("rst_wr_busy", wr_busy, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_m_rready", m_rready, 0);
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_wvalid", m_wvalid, 0);
    check("rst_m_bready", m_bready, 0);
    check("rst_s_arready", s_arready, 0);
    s_arvalid = '0;
    @(negedge clk) rst_n = 1'b1;
    tick;

    // 4-beat read from master 1 at 0x1000
    s_arvalid = 4'b0010; s_araddr[1] = 32'h1000; s_arlen[1] = 8'd3; s_arid[1] = 4'h5;
    s_rready = 4'b1111;
    #1;
    check("t1_pre_grant", rd_grant, 0);
    tick;
    check("t1_grant", rd_grant, 4'b0010);
    check("t1_busy", rd_busy, 1);
    check("t1_arvalid", m_arvalid, 1);
    check("t1_araddr", m_araddr, 32'h1000);
    check("t1_arlen", m_arlen, 3);
    check("t1_arid", m_arid, 5);
    m_arready = 1'b1;
    #1;
    check("t1_s_arready", s_arready, 4'b0010);
    tick;
    s_arvalid = '0; m_arready = 1'b0;
    #1;
    check("t1_arvalid_off", m_arvalid, 0);
    for (int k = 0; k < 4; k++) begin
      m_rvalid = 1'b1; m_rdata = 32'hD000 + k; m_rlast = (k == 3);
      #1;
      check("t1_rvalid", s_rvalid, 4'b0010);
      check("t1_rready", m_rready, 1);
      check("t1_rdata", s_rdata, 32'hD000 + k);
      tick;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("t1_release", rd_grant, 0);
    check("t1_idle", rd_busy, 0);

    // reset so the round-robin sequence starts from pointer 0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick;

    // all four request continuously: RR 0,1,2,3,0; fixed priority always 0
    s_arvalid = 4'b1111;
    rd_single("rr0", 4'b0001, 4'b0001);
    rd_single("rr1", 4'b0010, 4'b0001);
    rd_single("rr2", 4'b0100, 4'b0001);
    rd_single("rr3", 4'b1000, 4'b0001);
    rd_single("rr4", 4'b0001, 4'b0001);
    // masters 0 and 2 only; RR pointer is at 1 so it picks 2, then 0, then 2
    s_arvalid = 4'b0101;
    rd_single("fp0", 4'b0100, 4'b0001);
    rd_single("fp1", 4'b0001, 4'b0001);
    rd_single("fp2", 4'b0100, 4'b0001);
    s_arvalid = '0;

    // concurrent: master 0 writes 2 beats to 0x2000, master 1 reads 0x3000
    s_awvalid = 4'b0001; s_awaddr[0] = 32'h2000; s_awlen[0] = 8'd1;
    s_arvalid = 4'b0010; s_araddr[1] = 32'h3000; s_arlen[1] = 8'd0;
    s_bready = 4'b1111;
    tick;
    check("cc_wr_grant", wr_grant, 4'b0001);
    check("cc_rd_grant", rd_grant, 4'b0010);
    check("cc_awaddr", m_awaddr, 32'h2000);
    check("cc_araddr", m_araddr, 32'h3000);
    m_awready = 1'b1; m_arready = 1'b1;
    tick;
    s_awvalid = '0; s_arvalid = '0; m_awready = 1'b0; m_arready = 1'b0;
    s_wvalid = 4'b0001; s_wdata[0] = 32'hA0; s_wlast[0] = 1'b0; m_wready = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    #1;
    check("cc_wvalid", m_wvalid, 1);
    check("cc_wdata0", m_wdata, 32'hA0);
    check("cc_s_wready", s_wready, 4'b0001);
    check("cc_r_route", s_rvalid, 4'b0010);
    tick;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    s_wdata[0] = 32'hA1; s_wlast[0] = 1'b1;
    #1;
    check("cc_wdata1", m_wdata, 32'hA1);
    check("cc_wlast", m_wlast, 1);
    check("cc_rd_done", rd_grant, 0);
    tick;
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
    m_bvalid = 1'b1;
    #1;
    check("cc_b_route", s_bvalid, 4'b0001);
    check("cc_bready", m_bready, 1);
    tick;
    m_bvalid = 1'b0;
    check("cc_wr_release", wr_grant, 0);

    // 8-beat write from master 2 with downstream wready pattern 1,0,0,1
    s_awvalid = 4'b0100; s_awaddr[2] = 32'h4000; s_awlen[2] = 8'd7;
    tick;
    check("bp_grant", wr_grant, 4'b0100);
    m_awready = 1'b1;
    #1;
    check("bp_s_awready", s_awready, 4'b0100);
    tick;
    s_awvalid = '0; m_awready = 1'b0;
    s_wvalid = 4'b0100;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 40) begin
      s_wdata[2] = 32'hB0 + beat;
      s_wlast[2] = (beat == 7);
      m_wready   = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      check("bp_wdata", m_wdata, 32'hB0 + beat);
      check("bp_wvalid", m_wvalid, 1);
      check("bp_no_resp", m_bready, 0);
      hs = m_wready;
      tick;
      if (hs) beat++;
      cyc++;
    end
    check("bp_beats", beat, 8);
    check("bp_cycles", cyc, 16);
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
    #1;
    check("bp_resp_state", m_bready, 1);
    check("bp_wvalid_off", m_wvalid, 0);
    m_bvalid = 1'b1;
    tick;
    m_bvalid = 1'b0;
    check("bp_release", wr_grant, 0);

    // reset mid-burst in RD_DATA
    s_arvalid = 4'b1000; s_arlen[3] = 8'd3;
    tick;
    check("mr_grant", rd_grant, 4'b1000);
    m_arready = 1'b1;
    tick;
    s_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rlast = 1'b0;
    #1;
    check("mr_rready", m_rready, 1);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_grant_clr", rd_grant, 0);
    check("mr_rready_clr", m_rready, 0);
    check("mr_busy_clr", rd_busy, 0);
    check("mr_rvalid_clr", s_rvalid, 0);
    m_rvalid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick;
    // both pointers are back at 0, so the lowest requester at or after 0 wins
    s_arvalid = 4'b0101;
    s_awvalid = 4'b1010;
    tick;
    check("pr_rd_grant", rd_grant, 4'b0001);
    check("pr_wr_grant", wr_grant, 4'b0010);
    check("pr_fp_wr_grant", fp_wr_grant, 4'b0010);
    s_arvalid = '0; s_awvalid = '0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
